kaktovik_segment_encoder: RTL and testbench
===========================================

Name: kaktovik_segment_encoder

Overview:
- Reverse path of the Kaktovik 8-segment display decoder: samples a live 8-segment pattern (a..h) and recovers the 5-bit Kaktovik digit value.
- Debounces the pattern and classifies it as digit, blank or invalid.
- Presents each newly stable glyph once on a valid/ready output port.
- Used for display loop-back checking and for glyph-entry panels that feed the ubcd datapath.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (min 1, max 255).
- CNT_W, 8, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- AL   input  1  active level of SEG: 1 = segment lit when bit is 1; 0 = inverted (the pattern is XORed with ~AL before use).
- SEG  input  8  segment lines; bit0 = a … bit7 = h.
- out_ready  input  1  consumer accepts the output word.
- out_valid  output  1  output word is held and valid.
- VALUE  output  5  decoded digit 0..29.
- V      output  1  VALUE >= 20 (vigesimal-extended glyph).
- BLANK  output  1  pattern was all segments off.
- ERR    output  1  pattern matches no glyph; VALUE = 0.
- OVR    output  1  sticky: a stable glyph was dropped because the pending slot was full; cleared only by rst.

Behaviour:
- Normalised pattern P = SEG ^ {8{~AL}}, registered once (1-cycle input stage). The registered AL/SEG sample is what is compared.
- Glyph map (P → VALUE):
  - 00000100 → 0; 00000000 → BLANK (VALUE 0).
  - 01,07,0F,1F → 1..4.
  - 20,21,27,2F,3F → 5..9.
  - 60,61,67,6F,7F → 10..14.
  - E0,E1,E7,EF → 15..18; FF → 19 (never 30).
  - C0,C1,C7,CF,DF → 20..24.
  - A0,A1,A7,AF,BF → 25..29.
  - Anything else → ERR.
- Classification is a pure combinational function of P.
- Stability FSM:
  - SETTLE: counter cnt tracks how long P has equalled last_P. On change, load last_P = P and cnt = 1. When cnt reaches STABLE_CYCLES, go to LOCKED and emit the classified word.
  - LOCKED: holds with no re-emission while P == last_P. On change, go to SETTLE with cnt = 1.
  - The counter saturates and never wraps.
- Emission and output register:
  - If out_valid = 0, the word loads into the output register and out_valid rises the next cycle.
  - If out_valid = 1 and not consumed this cycle, the word goes to a 1-entry pending slot. If the slot is already full, the new word overwrites it and OVR is set.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - On the transfer cycle the pending word (if any) moves to the output register, keeping out_valid = 1; otherwise out_valid drops.
  - If an emission coincides with a transfer and the slot is empty, the new word goes straight to the output register.
  - VALUE/V/BLANK/ERR are stable while out_valid & ~out_ready.
- Latency: a pattern applied at cycle 0 and held gives out_valid at cycle STABLE_CYCLES+1 (4 → cycle 5).
- Reset (any time, including mid-settle or while holding): state SETTLE, cnt = 0, last_P = 00000000, pending empty. Outputs: out_valid = 0, VALUE = 0, V = 0, BLANK = 0, ERR = 0, OVR = 0. The first post-reset pattern, including blank, needs the full STABLE_CYCLES before emission.
- An AL change is treated as a pattern change and restarts settling.

Decomposition:
- Package kaktovik_pkg:
  - Glyph constants (GLYPH_ZERO = 8'h04, GLYPH_BLANK = 8'h00, per-digit patterns).
  - Function glyph_to_value returning {err, blank, value[4:0]}.
  - FSM state enum {SETTLE, LOCKED}.
- One natural sub-module: kaktovik_glyph_classify (combinational P → VALUE/V/BLANK/ERR), shareable with future checkers.
- The FSM, pending slot and output register stay in the top.

Test Plan:
- AL = 1, SEG = 8'h2F held 10 cycles, out_ready = 1 → single word VALUE = 8, V = 0, out_valid at cycle 5 only; no repeat.
- AL = 0, SEG = ~8'hDF = 8'h20 held → VALUE = 24, V = 1, ERR = 0.
- SEG toggles 8'h07/8'h0F every 3 cycles (STABLE_CYCLES = 4) → no emission; then hold 8'h0F → VALUE = 3 once.
- SEG = 8'h55 held → ERR = 1, VALUE = 0; SEG = 8'h00 → BLANK = 1; SEG = 8'hFF → VALUE = 19.
- out_ready = 0; stable 1, then 2, then 3 → output holds 1, pending 3, OVR = 1; raise ready → words 1 then 3, out_valid drops.
- rst asserted at cycle 2 of settling 8'h01 → next cycle out_valid = 0, OVR = 0; word appears STABLE_CYCLES+1 cycles after rst deasserts.

Source files
------------

// File: rtl/kaktovik_pkg.sv
// Shared Kaktovik glyph definitions: segment patterns, the decoded output word,
// and the pattern-to-digit lookup used by the encoder and any future checkers.
package kaktovik_pkg;

  typedef enum logic {SETTLE, LOCKED} state_t;

  typedef struct packed {
    logic       err;
    logic       blank;
    logic       v;
    logic [4:0] value;
  } word_t;

  localparam logic [7:0] GLYPH_ZERO  = 8'h04;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  // Index is the digit value; 19 is the all-on glyph and no pattern maps to 30.
  localparam logic [7:0] GLYPH_TBL [30] = '{
    8'h04, 8'h01, 8'h07, 8'h0F, 8'h1F,
    8'h20, 8'h21, 8'h27, 8'h2F, 8'h3F,
    8'h60, 8'h61, 8'h67, 8'h6F, 8'h7F,
    8'hE0, 8'hE1, 8'hE7, 8'hEF, 8'hFF,
    8'hC0, 8'hC1, 8'hC7, 8'hCF, 8'hDF,
    8'hA0, 8'hA1, 8'hA7, 8'hAF, 8'hBF
  };

  // Returns {err, blank, value}.
  function automatic logic [6:0] glyph_to_value(input logic [7:0] p);
    logic [6:0] r;
    r = {1'b1, 1'b0, 5'd0};
    if (p == GLYPH_BLANK) r = {1'b0, 1'b1, 5'd0};
    for (int i = 0; i < 30; i++) begin
      if (p == GLYPH_TBL[i]) r = {2'b00, 5'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/kaktovik_glyph_classify.sv
// Combinational classifier: normalised segment pattern to Kaktovik digit,
// blank or invalid.
module kaktovik_glyph_classify
  import kaktovik_pkg::*;
(
  input  logic [7:0] pat,
  output logic [4:0] value,
  output logic       v,
  output logic       blank,
  output logic       err
);

  logic [6:0] res;

  assign res                 = glyph_to_value(pat);
  assign {err, blank, value} = res;
  assign v                   = (value >= 5'd20);

endmodule

// File: rtl/kaktovik_segment_encoder.sv
// Samples a live 8-segment Kaktovik pattern, debounces it, and presents each
// newly stable glyph once on a valid/ready port with a one-entry overflow slot.
module kaktovik_segment_encoder
  import kaktovik_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AL,
  input  logic [7:0] SEG,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [4:0] VALUE,
  output logic       V,
  output logic       BLANK,
  output logic       ERR,
  output logic       OVR
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // Stage p0: raw input sample; vld_p0 keeps the reset-time sample out of the count.
  logic       al_p0;
  logic [7:0] seg_p0;
  logic       vld_p0;
  logic [7:0] pat_p0;

  always_ff @(posedge clk) begin
    al_p0  <= AL;
    seg_p0 <= SEG;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= 1'b1;
  end

  assign pat_p0 = seg_p0 ^ {8{~al_p0}};

  word_t cls_word;

  kaktovik_glyph_classify u_classify (
    .pat   (pat_p0),
    .value (cls_word.value),
    .v     (cls_word.v),
    .blank (cls_word.blank),
    .err   (cls_word.err)
  );

  // Stability tracking compares the raw {AL, SEG} so an AL flip restarts settling.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       last_q, last_d;
  logic             emit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    emit    = 1'b0;
    if (vld_p0) begin
      if ({al_p0, seg_p0} != last_q) begin
        last_d  = {al_p0, seg_p0};
        cnt_d   = CNT_W'(1);
        state_d = SETTLE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (state_d == SETTLE && cnt_d == STABLE_CNT) begin
        emit    = 1'b1;
        state_d = LOCKED;
      end
    end
  end

  // Stage p1: output register plus pending slot.
  word_t word_p1, word_d;
  logic  vld_p1, vld_d;
  word_t pnd_q, pnd_d;
  logic  pnd_vld_q, pnd_vld_d;
  logic  ovr_q, ovr_d;
  logic  xfer;

  assign xfer = vld_p1 & out_ready;

  always_comb begin
    word_d    = word_p1;
    vld_d     = vld_p1;
    pnd_d     = pnd_q;
    pnd_vld_d = pnd_vld_q;
    ovr_d     = ovr_q;
    if (xfer) begin
      if (pnd_vld_q) begin
        word_d    = pnd_q;
        pnd_vld_d = emit;
        if (emit) pnd_d = cls_word;
      end else if (emit) begin
        word_d = cls_word;
      end else begin
        vld_d = 1'b0;
      end
    end else if (emit) begin
      if (!vld_p1) begin
        word_d = cls_word;
        vld_d  = 1'b1;
      end else begin
        pnd_d     = cls_word;
        pnd_vld_d = 1'b1;
        if (pnd_vld_q) ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SETTLE;
      cnt_q     <= '0;
      last_q    <= {1'b1, GLYPH_BLANK};
      word_p1   <= '0;
      vld_p1    <= 1'b0;
      pnd_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      word_p1   <= word_d;
      vld_p1    <= vld_d;
      pnd_vld_q <= pnd_vld_d;
      ovr_q     <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    pnd_q <= pnd_d;
  end

  assign out_valid = vld_p1;
  assign VALUE     = word_p1.value;
  assign V         = word_p1.v;
  assign BLANK     = word_p1.blank;
  assign ERR       = word_p1.err;
  assign OVR       = ovr_q;

endmodule

// File: tb/tb_kaktovik_segment_encoder.sv
// Directed bench for the Kaktovik segment encoder with STABLE_CYCLES = 4.
module tb_kaktovik_segment_encoder;

  logic       clk;
  logic       rst;
  logic       AL;
  logic [7:0] SEG;
  logic       out_ready;
  logic       out_valid;
  logic [4:0] VALUE;
  logic       V;
  logic       BLANK;
  logic       ERR;
  logic       OVR;

  int checks = 0;
  int errors = 0;

  kaktovik_segment_encoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .AL        (AL),
    .SEG       (SEG),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .VALUE     (VALUE),
    .V         (V),
    .BLANK     (BLANK),
    .ERR       (ERR),
    .OVR       (OVR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a pattern for n edges; report the first edge with out_valid high,
  // how many edges had it high, and the word seen on that first edge.
  task automatic hold(input logic al, input logic [7:0] seg, input int n,
                      output int first, output int nv, output logic [4:0] val,
                      output logic v, output logic bl, output logic er);
    AL = al; SEG = seg;
    first = -1; nv = 0; val = '0; v = 1'b0; bl = 1'b0; er = 1'b0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (out_valid) begin
        nv++;
        if (first < 0) begin
          first = i; val = VALUE; v = V; bl = BLANK; er = ERR;
        end
      end
    end
  endtask

  int         f, n;
  logic [4:0] val;
  logic       vv, bl, er;

  task automatic test_reset();
    rst = 1'b1; AL = 1'b1; SEG = 8'h00; out_ready = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (VALUE !== 5'd0)     begin errors++; $display("FAIL reset_value got %0d want 0", VALUE); end
    checks++; if (V !== 1'b0)         begin errors++; $display("FAIL reset_v got %b want 0", V); end
    checks++; if (BLANK !== 1'b0)     begin errors++; $display("FAIL reset_blank got %b want 0", BLANK); end
    checks++; if (ERR !== 1'b0)       begin errors++; $display("FAIL reset_err got %b want 0", ERR); end
    checks++; if (OVR !== 1'b0)       begin errors++; $display("FAIL reset_ovr got %b want 0", OVR); end
    rst = 1'b0; out_ready = 1'b1;
    hold(1'b1, 8'h00, 8, f, n, val, vv, bl, er);
    checks++; if (f != 5)      begin errors++; $display("FAIL post_reset_blank_latency got %0d want 5", f); end
    checks++; if (n != 1)      begin errors++; $display("FAIL post_reset_blank_count got %0d want 1", n); end
    checks++; if (bl !== 1'b1) begin errors++; $display("FAIL post_reset_blank_flag got %b want 1", bl); end
  endtask

  task automatic test_single_emit();
    out_ready = 1'b1;
    hold(1'b1, 8'h2F, 10, f, n, val, vv, bl, er);
    checks++; if (f != 5)       begin errors++; $display("FAIL single_latency got %0d want 5", f); end
    checks++; if (n != 1)       begin errors++; $display("FAIL single_count got %0d want 1", n); end
    checks++; if (val !== 5'd8) begin errors++; $display("FAIL single_value got %0d want 8", val); end
    checks++; if (vv !== 1'b0)  begin errors++; $display("FAIL single_v got %b want 0", vv); end
  endtask

  task automatic test_inverted();
    hold(1'b0, 8'h20, 10, f, n, val, vv, bl, er);
    checks++; if (f != 5)        begin errors++; $display("FAIL inv_latency got %0d want 5", f); end
    checks++; if (n != 1)        begin errors++; $display("FAIL inv_count got %0d want 1", n); end
    checks++; if (val !== 5'd24) begin errors++; $display("FAIL inv_value got %0d want 24", val); end
    checks++; if (vv !== 1'b1)   begin errors++; $display("FAIL inv_v got %b want 1", vv); end
    checks++; if (er !== 1'b0)   begin errors++; $display("FAIL inv_err got %b want 0", er); end
  endtask

  task automatic test_bounce();
    int total;
    total = 0;
    for (int k = 0; k < 5; k++) begin
      hold(1'b1, (k % 2 == 0) ? 8'h07 : 8'h0F, 3, f, n, val, vv, bl, er);
      total += n;
    end
    checks++; if (total != 0) begin errors++; $display("FAIL bounce_no_emit got %0d want 0", total); end
    hold(1'b1, 8'h0F, 10, f, n, val, vv, bl, er);
    checks++; if (f != 5)       begin errors++; $display("FAIL bounce_latency got %0d want 5", f); end
    checks++; if (n != 1)       begin errors++; $display("FAIL bounce_count got %0d want 1", n); end
    checks++; if (val !== 5'd3) begin errors++; $display("FAIL bounce_value got %0d want 3", val); end
  endtask

  task automatic test_classes();
    logic [7:0] pats [6];
    logic [4:0] ev   [6];
    logic       ee   [6];
    logic       eb   [6];
    logic       evv  [6];
    pats = '{8'h55, 8'h00, 8'hFF, 8'h04, 8'hBF, 8'hC7};
    ev   = '{5'd0, 5'd0, 5'd19, 5'd0, 5'd29, 5'd22};
    ee   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    eb   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    evv  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      hold(1'b1, pats[k], 8, f, n, val, vv, bl, er);
      checks++; if (n != 1)       begin errors++; $display("FAIL class_count pat=%h got %0d want 1", pats[k], n); end
      checks++; if (val !== ev[k]) begin errors++; $display("FAIL class_value pat=%h got %0d want %0d", pats[k], val, ev[k]); end
      checks++; if (er !== ee[k])  begin errors++; $display("FAIL class_err pat=%h got %b want %b", pats[k], er, ee[k]); end
      checks++; if (bl !== eb[k])  begin errors++; $display("FAIL class_blank pat=%h got %b want %b", pats[k], bl, eb[k]); end
      checks++; if (vv !== evv[k]) begin errors++; $display("FAIL class_v pat=%h got %b want %b", pats[k], vv, evv[k]); end
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    hold(1'b1, 8'h01, 6, f, n, val, vv, bl, er);
    hold(1'b1, 8'h07, 6, f, n, val, vv, bl, er);
    checks++; if (OVR !== 1'b0) begin errors++; $display("FAIL bp_ovr_early got %b want 0", OVR); end
    hold(1'b1, 8'h0F, 6, f, n, val, vv, bl, er);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b want 1", out_valid); end
    checks++; if (VALUE !== 5'd1)     begin errors++; $display("FAIL bp_hold_value got %0d want 1", VALUE); end
    checks++; if (OVR !== 1'b1)       begin errors++; $display("FAIL bp_ovr got %b want 1", OVR); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %b want 1", out_valid); end
    checks++; if (VALUE !== 5'd3)     begin errors++; $display("FAIL bp_second_value got %0d want 3", VALUE); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %b want 0", out_valid); end
    checks++; if (OVR !== 1'b1)       begin errors++; $display("FAIL bp_ovr_sticky got %b want 1", OVR); end
  endtask

  task automatic test_reset_mid_settle();
    out_ready = 1'b1;
    AL = 1'b1; SEG = 8'h01;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    checks++; if (OVR !== 1'b0)       begin errors++; $display("FAIL mid_rst_ovr got %b want 0", OVR); end
    rst = 1'b0;
    hold(1'b1, 8'h01, 8, f, n, val, vv, bl, er);
    checks++; if (f != 5)       begin errors++; $display("FAIL mid_rst_latency got %0d want 5", f); end
    checks++; if (val !== 5'd1) begin errors++; $display("FAIL mid_rst_value got %0d want 1", val); end
  endtask

  initial begin
    rst = 1'b1; AL = 1'b1; SEG = 8'h00; out_ready = 1'b0;
    test_reset();
    test_single_emit();
    test_inverted();
    test_bounce();
    test_classes();
    test_back_pressure();
    test_reset_mid_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
